// File: rtl/axis_packet_deframer.sv
// RX deframer: merges PMTU-sized packets into one DMA payload stream with a single tlast and
// emits one completion record per transfer. Optional macro RX_DEFRAMER_STATS_EN adds statistics counters.
module axis_packet_deframer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [14:0]             s_axis_tuser,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    m_cpl_valid,
    input  logic                    m_cpl_ready,
    output logic [31:0]             m_cpl_length,
    output logic [15:0]             m_cpl_pkt_count,
    output logic                    m_cpl_error,
    input  logic [2:0]              pmtu
`ifdef RX_DEFRAMER_STATS_EN
    ,
    output logic [31:0]             stat_transfers,
    output logic [31:0]             stat_errors,
    output logic [31:0]             stat_pkts
`endif
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [13:0] BEAT_BYTES = 14'(BYTES);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_CPL = 2'd2} state_t;

    function automatic logic [12:0] pmtu_bytes(input logic [2:0] code);
        logic [12:0] b;
        case (code)
            3'd0:    b = 13'd256;
            3'd1:    b = 13'd512;
            3'd2:    b = 13'd1024;
            3'd3:    b = 13'd2048;
            default: b = 13'd4096;
        endcase
        return b;
    endfunction

    function automatic logic [13:0] popcount(input logic [BYTES-1:0] keep);
        logic [13:0] n;
        n = 14'd0;
        for (int i = 0; i < BYTES; i++) n = n + {13'd0, keep[i]};
        return n;
    endfunction

    state_t                  state_r, state_s;
    logic                    ready_r;
    logic                    out_valid_r, skid_valid_r, skid_valid_s;
    logic [DATA_WIDTH-1:0]   out_data_r, skid_data_r;
    logic [BYTES-1:0]        out_keep_r, skid_keep_r;
    logic                    out_last_r, skid_last_r, out_user_r, skid_user_r;
    logic [12:0]             pkt_len_r, pkt_len_s, pmtu_b_r, pmtu_b_s;
    logic [13:0]             pkt_bytes_r, pkt_bytes_s;
    logic                    first_r, first_s, err_r, err_s, cpl_valid_r;
    logic [31:0]             xfer_len_r, xfer_len_s;
    logic [15:0]             pkt_cnt_r, pkt_cnt_s;

    logic                    accept_s, out_free_s, cpl_hs_s, idle_s, pkt_first_s;
    logic [12:0]             cur_len_s, cur_pmtu_s;
    logic [13:0]             beat_bytes_s, pkt_sum_s;
    logic [14:0]             raw_sum_s;
    logic                    sat_s, beat_err_s, err_base_s, in_last_s, in_user_s;

    // Per-beat byte accounting and packet checks on the input beat
    always_comb begin
        accept_s     = s_axis_tvalid & ready_r;
        out_free_s   = ~out_valid_r | m_axis_tready;
        cpl_hs_s     = cpl_valid_r & m_cpl_ready;
        idle_s       = (state_r == ST_IDLE);
        pkt_first_s  = idle_s | first_r;
        cur_len_s    = pkt_first_s ? s_axis_tuser[14:2] : pkt_len_r;
        cur_pmtu_s   = idle_s ? pmtu_bytes(pmtu) : pmtu_b_r;
        beat_bytes_s = s_axis_tlast ? popcount(s_axis_tkeep) : BEAT_BYTES;
        raw_sum_s    = {1'b0, (pkt_first_s ? 14'd0 : pkt_bytes_r)} + {1'b0, beat_bytes_s};
        sat_s        = (raw_sum_s > 15'd8191);
        pkt_sum_s    = sat_s ? 14'd8191 : raw_sum_s[13:0];
        beat_err_s   = s_axis_tuser[0]
                     | (~s_axis_tlast & (s_axis_tkeep != {BYTES{1'b1}}))
                     | (s_axis_tlast & (sat_s | (pkt_sum_s != {1'b0, cur_len_s})))
                     | (s_axis_tlast & ~s_axis_tuser[1] & (cur_len_s != cur_pmtu_s))
                     | (s_axis_tlast & s_axis_tuser[1] &
                        ((cur_len_s == 13'd0) | (cur_len_s > cur_pmtu_s)));
        err_base_s   = idle_s ? 1'b0 : err_r;
        in_last_s    = s_axis_tlast & s_axis_tuser[1];
        in_user_s    = in_last_s & (err_base_s | beat_err_s);
        if (accept_s && (skid_valid_r || !out_free_s)) begin
            skid_valid_s = 1'b1;
        end else if (out_free_s) begin
            skid_valid_s = 1'b0;
        end else begin
            skid_valid_s = skid_valid_r;
        end
    end

    // Transfer FSM next-state and accumulator updates
    always_comb begin
        state_s     = state_r;
        pkt_len_s   = pkt_len_r;
        pmtu_b_s    = pmtu_b_r;
        pkt_bytes_s = pkt_bytes_r;
        first_s     = first_r;
        err_s       = err_r;
        xfer_len_s  = xfer_len_r;
        pkt_cnt_s   = pkt_cnt_r;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                if (accept_s) begin
                    xfer_len_s  = (idle_s ? 32'd0 : xfer_len_r) + {18'd0, beat_bytes_s};
                    pkt_cnt_s   = (idle_s ? 16'd0 : pkt_cnt_r) + {15'd0, s_axis_tlast};
                    err_s       = err_base_s | beat_err_s;
                    pkt_len_s   = cur_len_s;
                    pmtu_b_s    = cur_pmtu_s;
                    pkt_bytes_s = pkt_sum_s;
                    first_s     = s_axis_tlast;
                    state_s     = in_last_s ? ST_CPL : ST_DATA;
                end else begin
                    state_s = state_r;
                end
            end
            ST_CPL: begin
                if (cpl_hs_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_CPL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pkt_len_r   <= 13'd0;
            pmtu_b_r    <= 13'd0;
            pkt_bytes_r <= 14'd0;
            first_r     <= 1'b0;
            err_r       <= 1'b0;
            xfer_len_r  <= 32'd0;
            pkt_cnt_r   <= 16'd0;
            cpl_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pkt_len_r   <= pkt_len_s;
            pmtu_b_r    <= pmtu_b_s;
            pkt_bytes_r <= pkt_bytes_s;
            first_r     <= first_s;
            err_r       <= err_s;
            xfer_len_r  <= xfer_len_s;
            pkt_cnt_r   <= pkt_cnt_s;
            cpl_valid_r <= (state_s == ST_CPL);
        end
    end

    // Output register plus skid entry; ready is registered and closed while a completion is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_keep_r   <= '0;
            out_last_r   <= 1'b0;
            out_user_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_keep_r  <= '0;
            skid_last_r  <= 1'b0;
            skid_user_r  <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            if (out_free_s) begin
                if (skid_valid_r) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= skid_data_r;
                    out_keep_r  <= skid_keep_r;
                    out_last_r  <= skid_last_r;
                    out_user_r  <= skid_user_r;
                end else if (accept_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= s_axis_tdata;
                    out_keep_r  <= s_axis_tkeep;
                    out_last_r  <= in_last_s;
                    out_user_r  <= in_user_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
            if (accept_s && (skid_valid_r || !out_free_s)) begin
                skid_data_r <= s_axis_tdata;
                skid_keep_r <= s_axis_tkeep;
                skid_last_r <= in_last_s;
                skid_user_r <= in_user_s;
            end
            skid_valid_r <= skid_valid_s;
            ready_r      <= ~skid_valid_s & (state_s != ST_CPL);
        end
    end

`ifdef RX_DEFRAMER_STATS_EN
    logic [31:0] stat_transfers_r, stat_errors_r, stat_pkts_r;

    // Wrapping statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_transfers_r <= 32'd0;
            stat_errors_r    <= 32'd0;
            stat_pkts_r      <= 32'd0;
        end else begin
            if (cpl_hs_s) stat_transfers_r <= stat_transfers_r + 32'd1;
            if (cpl_hs_s && err_r) stat_errors_r <= stat_errors_r + 32'd1;
            if (accept_s && s_axis_tlast) stat_pkts_r <= stat_pkts_r + 32'd1;
        end
    end

    assign stat_transfers = stat_transfers_r;
    assign stat_errors    = stat_errors_r;
    assign stat_pkts      = stat_pkts_r;
`endif

    assign s_axis_tready   = ready_r;
    assign m_axis_tdata    = out_data_r;
    assign m_axis_tkeep    = out_keep_r;
    assign m_axis_tvalid   = out_valid_r;
    assign m_axis_tlast    = out_last_r;
    assign m_axis_tuser    = out_user_r;
    assign m_cpl_valid     = cpl_valid_r;
    assign m_cpl_length    = xfer_len_r;
    assign m_cpl_pkt_count = pkt_cnt_r;
    assign m_cpl_error     = err_r;

endmodule

// File: tb/tb_axis_packet_deframer.sv
// Self-checking bench for axis_packet_deframer: transfers are described as packet lists and
// expected beats/completions are derived from the packet rules, not from the RTL structure.
module tb_axis_packet_deframer;
    localparam int DW = 64;
    localparam int BY = DW / 8;

    typedef struct packed {logic [DW-1:0] d; logic [BY-1:0] k; logic l; logic [14:0] u;} in_beat_t;
    typedef struct packed {logic [DW-1:0] d; logic [BY-1:0] k; logic l; logic u;} out_beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [BY-1:0] s_axis_tkeep = '0;
    logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [14:0] s_axis_tuser = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [BY-1:0] m_axis_tkeep;
    logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, m_axis_tuser;
    logic m_cpl_valid, m_cpl_ready = 1'b0, m_cpl_error;
    logic [31:0] m_cpl_length;
    logic [15:0] m_cpl_pkt_count;
    logic [2:0] pmtu = 3'd0;
`ifdef RX_DEFRAMER_STATS_EN
    logic [31:0] stat_transfers, stat_errors, stat_pkts;
`endif

    int checks = 0;
    int errors = 0;
    in_beat_t  in_q[$];
    out_beat_t exp_q[$];
    out_beat_t got_q[$];
    int decl_q[$];
    int act_q[$];
    bit bad_q[$];
    bit rand_rdy = 1'b0, rand_gap = 1'b0, lat_check = 1'b0;
    logic [31:0] exp_len;
    int exp_cnt;
    bit exp_err;

    axis_packet_deframer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_cpl_valid(m_cpl_valid), .m_cpl_ready(m_cpl_ready), .m_cpl_length(m_cpl_length),
        .m_cpl_pkt_count(m_cpl_pkt_count), .m_cpl_error(m_cpl_error), .pmtu(pmtu)
`ifdef RX_DEFRAMER_STATS_EN
        , .stat_transfers(stat_transfers), .stat_errors(stat_errors), .stat_pkts(stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
    end

    // Reference model: expected merged beats and completion from the packet list
    task automatic build_transfer(input int code);
        int pb, n, nb, rem;
        bit last;
        in_beat_t b;
        out_beat_t o;
        in_q.delete(); exp_q.delete(); got_q.delete();
        pb = 256 << ((code > 4) ? 4 : code);
        n = decl_q.size();
        exp_len = 32'd0; exp_err = 1'b0; exp_cnt = n;
        for (int p = 0; p < n; p++) begin
            last = (p == n - 1);
            if (act_q[p] != decl_q[p]) exp_err = 1'b1;
            if (!last && decl_q[p] != pb) exp_err = 1'b1;
            if (last && (decl_q[p] == 0 || decl_q[p] > pb)) exp_err = 1'b1;
            if (bad_q[p]) exp_err = 1'b1;
            exp_len += 32'(act_q[p]);
            nb = (act_q[p] + BY - 1) / BY;
            for (int i = 0; i < nb; i++) begin
                rem = act_q[p] - i * BY;
                b.d = {$urandom, $urandom};
                b.k = (rem >= BY) ? {BY{1'b1}} : BY'((1 << rem) - 1);
                b.l = (i == nb - 1);
                b.u = {13'(decl_q[p]), last, bad_q[p] && (i == 0)};
                in_q.push_back(b);
            end
        end
        for (int i = 0; i < in_q.size(); i++) begin
            o.d = in_q[i].d; o.k = in_q[i].k;
            o.l = (i == in_q.size() - 1);
            o.u = o.l & exp_err;
            exp_q.push_back(o);
        end
        pmtu = 3'(code);
    endtask

    task automatic drive_beats(input int max_beats);
        int budget;
        for (int i = 0; i < in_q.size() && i < max_beats; i++) begin
            if (rand_gap) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata = in_q[i].d; s_axis_tkeep = in_q[i].k;
            s_axis_tlast = in_q[i].l; s_axis_tuser = in_q[i].u;
            budget = 0;
            @(negedge clk);
            while (!s_axis_tready && budget < 3000) begin @(negedge clk); budget++; end
            if (budget >= 3000) begin
                checks++; errors++;
                $display("FAIL drive_timeout: beat %0d not accepted, s_axis_tready=%b required 1", i, s_axis_tready);
                break;
            end
            @(posedge clk); #1;
            if (i == 0 && lat_check) begin
                checks++;
                if (m_axis_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: m_axis_tvalid=%b one cycle after first beat, required 1", m_axis_tvalid);
                end
            end
            if (i == 0 && rand_gap) pmtu = 3'($urandom_range(0, 7));
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic finish_transfer(input string name, input bit hold);
        int budget, mism, first_bad;
        bit bad;
        budget = 0;
        while (m_cpl_valid !== 1'b1 && budget < 6000) begin @(negedge clk); budget++; end
        checks++;
        if (m_cpl_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s cpl_timeout: m_cpl_valid=%b required 1", name, m_cpl_valid);
        end else begin
            if (hold) begin
                bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (s_axis_tready !== 1'b0 || m_cpl_valid !== 1'b1) bad = 1'b1;
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s cpl_hold: s_axis_tready/m_cpl_valid wrong while completion held", name);
                end
            end
            checks++;
            if (m_cpl_length !== exp_len) begin
                errors++; $display("FAIL %s cpl_length: got %0d required %0d", name, m_cpl_length, exp_len);
            end
            checks++;
            if (m_cpl_pkt_count !== 16'(exp_cnt)) begin
                errors++; $display("FAIL %s cpl_pkt_count: got %0d required %0d", name, m_cpl_pkt_count, exp_cnt);
            end
            checks++;
            if (m_cpl_error !== exp_err) begin
                errors++; $display("FAIL %s cpl_error: got %b required %b", name, m_cpl_error, exp_err);
            end
            @(posedge clk); #1 m_cpl_ready = 1'b1;
            @(posedge clk); #1 m_cpl_ready = 1'b0;
            checks++;
            if (m_cpl_valid !== 1'b0) begin
                errors++; $display("FAIL %s cpl_release: m_cpl_valid=%b required 0", name, m_cpl_valid);
            end
        end
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 6000) begin @(posedge clk); #1; budget++; end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        mism = 0; first_bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL %s beats: %0d wrong, first at %0d got last=%b user=%b keep=%h required last=%b user=%b keep=%h",
                     name, mism, first_bad, got_q[first_bad].l, got_q[first_bad].u, got_q[first_bad].k,
                     exp_q[first_bad].l, exp_q[first_bad].u, exp_q[first_bad].k);
        end
    endtask

    task automatic run_one(input string name, input int code, input bit hold);
        build_transfer(code);
        drive_beats(in_q.size());
        finish_transfer(name, hold);
    endtask

    task automatic set_pkts1(input int d0, input int a0, input bit b0);
        decl_q = '{d0}; act_q = '{a0}; bad_q = '{b0};
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b required 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b required 0", m_axis_tlast); end
        if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b required 0", m_axis_tuser); end
        if (m_cpl_valid !== 1'b0) begin errors++; $display("FAIL rst_cpl_valid: got %b required 0", m_cpl_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL idle_tready: got %b required 1", s_axis_tready); end
    endtask

    task automatic test_single;
        set_pkts1(100, 100, 1'b0);
        lat_check = 1'b1;
        run_one("single_100B", 0, 1'b0);
        lat_check = 1'b0;
    endtask

    task automatic test_multi_packet;
        decl_q = '{256, 256, 40}; act_q = '{256, 256, 40}; bad_q = '{0, 0, 0};
        run_one("three_pkts", 0, 1'b0);
    endtask

    task automatic test_len_mismatch;
        set_pkts1(256, 248, 1'b0);
        run_one("short_pkt", 0, 1'b0);
        checks++;
        if (got_q.size() == 0 || got_q[got_q.size()-1].u !== 1'b1) begin
            errors++; $display("FAIL short_pkt_final_tuser: final beat tuser not 1, required 1");
        end
    endtask

    task automatic test_pmtu_check;
        decl_q = '{512, 100}; act_q = '{512, 100}; bad_q = '{0, 0};
        run_one("pmtu_mismatch", 2, 1'b0);
        decl_q = '{1024, 200}; act_q = '{1024, 200}; bad_q = '{0, 0};
        run_one("pmtu_clean", 2, 1'b0);
    endtask

    task automatic test_boundaries;
        set_pkts1(0, 8, 1'b0);
        run_one("last_len_zero", 0, 1'b0);
        set_pkts1(300, 300, 1'b0);
        run_one("last_over_pmtu", 0, 1'b0);
        set_pkts1(64, 64, 1'b1);
        run_one("bad_frame", 0, 1'b0);
        decl_q = '{4096, 4096, 16}; act_q = '{4096, 4096, 16}; bad_q = '{0, 0, 0};
        run_one("pmtu_code6", 6, 1'b0);
    endtask

    task automatic test_backpressure;
        int code, pb, n, r;
        bit last;
        rand_rdy = 1'b1; rand_gap = 1'b1;
        for (int t = 0; t < 4; t++) begin
            code = $urandom_range(0, 7);
            pb = 256 << ((code > 4) ? 4 : code);
            n = $urandom_range(1, 3);
            decl_q.delete(); act_q.delete(); bad_q.delete();
            for (int p = 0; p < n; p++) begin
                last = (p == n - 1);
                decl_q.push_back(last ? $urandom_range(1, pb) : pb);
                act_q.push_back(decl_q[p]);
                bad_q.push_back(1'b0);
                r = $urandom_range(0, 9);
                if (r == 0 && decl_q[p] > 8) act_q[p] = decl_q[p] - 8;
                if (r == 1) bad_q[p] = 1'b1;
                if (r == 2 && !last) begin decl_q[p] = pb / 2; act_q[p] = pb / 2; end
            end
            run_one($sformatf("random_%0d", t), code, 1'b1);
        end
        rand_rdy = 1'b0; rand_gap = 1'b0;
    endtask

    task automatic test_reset_mid;
        int tl;
        set_pkts1(100, 100, 1'b0);
        build_transfer(0);
        drive_beats(10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b required 0", m_axis_tvalid); end
        if (m_cpl_valid !== 1'b0) begin errors++; $display("FAIL midrst_cpl_valid: got %b required 0", m_cpl_valid); end
        tl = 0;
        foreach (got_q[i]) if (got_q[i].l) tl++;
        checks++;
        if (tl != 0) begin errors++; $display("FAIL midrst_tlast: %0d tlast beats, required 0", tl); end
        set_pkts1(100, 100, 1'b0);
        run_one("after_reset", 0, 1'b0);
`ifdef RX_DEFRAMER_STATS_EN
        checks++;
        if (stat_pkts !== 32'd1) begin errors++; $display("FAIL stat_pkts: got %0d required 1", stat_pkts); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_packet();
        test_len_mismatch();
        test_pmtu_check();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
